// File: rtl/block_drawer_if.sv
// block_drawer_if: groups the request side (start plus block geometry) and the
// VGA pixel side (x/y/colour/plot) with the busy/done status of block_drawer.
// The caller drives through the master modport. The drawer uses the slave modport.
interface block_drawer_if;
    logic       start;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [7:0] width_in;
    logic [2:0] colour_in;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;
    logic       done;

    modport master (
        output start, x_in, y_in, width_in, colour_in,
        input  vga_x, vga_y, vga_colour, plot, busy, done
    );

    modport slave (
        input  start, x_in, y_in, width_in, colour_in,
        output vga_x, vga_y, vga_colour, plot, busy, done
    );
endinterface

// File: rtl/block_drawer.sv
// block_drawer: turns a block request (x, y, width, colour) into a stream of
// single-pixel writes for the VGA adapter, one pixel per clock. The optional
// erase pass (macro BLOCK_DRAWER_ERASE_EN) first repaints the previously drawn
// rectangle in BG_COLOUR. Without the macro, every request goes straight to DRAW.
// Pixels whose x lands at or beyond SCREEN_W are suppressed (plot low), but
// they still take a cycle, so the operation length depends only on the sizes.
module block_drawer #(
    parameter int unsigned BLOCK_H   = 8,
    parameter int unsigned SCREEN_W  = 160,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input logic           clk,
    input logic           reset,
    block_drawer_if.slave bus
);

    localparam int unsigned     PY_W    = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;
    localparam logic [PY_W-1:0] PY_LAST = PY_W'(BLOCK_H - 1);
    localparam logic [8:0]      X_LIMIT = 9'(SCREEN_W);

`ifdef BLOCK_DRAWER_ERASE_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ERASE  = 2'd1,
        DRAW   = 2'd2,
        FINISH = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAW   = 2'd2,
        FINISH = 2'd3
    } state_t;
`endif

    state_t state_q, state_d;

    // Pixel counters: px runs fastest across the row, py steps down the rows.
    logic [7:0]      px_q, px_d;
    logic [PY_W-1:0] py_q, py_d;

    // New block, captured on an accepted start and held for the whole operation.
    logic [7:0] new_x_q;
    logic [6:0] new_y_q;
    logic [7:0] new_w_q;
    logic [2:0] new_c_q;
    logic       latch_en;

    // Registered outputs and their next values.
    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // Geometry of the pass currently being rasterised.
    logic [7:0] cur_x;
    logic [6:0] cur_y;
    logic [7:0] cur_w;
    logic [2:0] cur_c;
    logic       in_erase;

    logic [8:0] pix_sum;
    logic       row_end;
    logic       last_pixel;

`ifdef BLOCK_DRAWER_ERASE_EN
    // Last completed block, remembered so that the next request can erase it.
    logic [7:0] prev_x_q;
    logic [6:0] prev_y_q;
    logic [7:0] prev_w_q;
    logic       prev_valid_q;
    logic       commit_prev;
    logic       erase_needed;

    assign in_erase     = (state_q == ERASE);
    assign erase_needed = prev_valid_q && (prev_w_q != 8'd0);
`else
    assign in_erase = 1'b0;
`endif

    // Select the rectangle for the active pass: the old block while erasing, otherwise the new one.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        cur_x = new_x_q;
        cur_y = new_y_q;
        cur_w = new_w_q;
`ifdef BLOCK_DRAWER_ERASE_EN
        if (in_erase) begin
            cur_x = prev_x_q;
            cur_y = prev_y_q;
            cur_w = prev_w_q;
        end
`endif
        cur_c = in_erase ? BG_COLOUR : new_c_q;
    end

    // The 9-bit sum catches both x >= SCREEN_W and 8-bit wrap-around in one compare.
    assign pix_sum    = {1'b0, cur_x} + {1'b0, px_q};
    assign row_end    = (px_q == cur_w - 8'd1);
    assign last_pixel = row_end && (py_q == PY_LAST);

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d  = state_q;
        px_d     = px_q;
        py_d     = py_q;
        latch_en = 1'b0;
        vga_x_d  = vga_x_q;
        vga_y_d  = vga_y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef BLOCK_DRAWER_ERASE_EN
        commit_prev = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    latch_en = 1'b1;
                    busy_d   = 1'b1;
                    px_d     = 8'd0;
                    py_d     = '0;
                    // A zero-width block has nothing to draw, so it goes straight to FINISH.
                    if (bus.width_in == 8'd0) begin
                        state_d = FINISH;
                    end else begin
                        state_d = DRAW;
                    end
`ifdef BLOCK_DRAWER_ERASE_EN
                    if (erase_needed) begin
                        state_d = ERASE;
                    end
`endif
                end
            end

`ifdef BLOCK_DRAWER_ERASE_EN
            ERASE,
`endif
            DRAW: begin
                vga_x_d  = pix_sum[7:0];
                vga_y_d  = cur_y + 7'(py_q);
                colour_d = cur_c;
                plot_d   = (pix_sum < X_LIMIT);
                if (row_end) begin
                    px_d = 8'd0;
                    py_d = (py_q == PY_LAST) ? '0 : py_q + 1'b1;
                end else begin
                    px_d = px_q + 8'd1;
                end
                if (last_pixel) begin
                    state_d = FINISH;
`ifdef BLOCK_DRAWER_ERASE_EN
                    // Erase flows into the draw pass with no bubble, unless the new block is empty.
                    if (in_erase && (new_w_q != 8'd0)) begin
                        state_d = DRAW;
                    end
`endif
                end
            end

            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
`ifdef BLOCK_DRAWER_ERASE_EN
                commit_prev = 1'b1;
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, captured request fields and registered pixel outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            px_q     <= 8'd0;
            py_q     <= '0;
            new_x_q  <= 8'd0;
            new_y_q  <= 7'd0;
            new_w_q  <= 8'd0;
            new_c_q  <= 3'd0;
            vga_x_q  <= 8'd0;
            vga_y_q  <= 7'd0;
            colour_q <= 3'd0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            px_q     <= px_d;
            py_q     <= py_d;
            vga_x_q  <= vga_x_d;
            vga_y_q  <= vga_y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            if (latch_en) begin
                new_x_q <= bus.x_in;
                new_y_q <= bus.y_in;
                new_w_q <= bus.width_in;
                new_c_q <= bus.colour_in;
            end
        end
    end

`ifdef BLOCK_DRAWER_ERASE_EN
    // Remember the block just completed. A reset forgets it, so the next request skips the erase pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_x_q     <= 8'd0;
            prev_y_q     <= 7'd0;
            prev_w_q     <= 8'd0;
            prev_valid_q <= 1'b0;
        end else if (commit_prev) begin
            prev_x_q     <= new_x_q;
            prev_y_q     <= new_y_q;
            prev_w_q     <= new_w_q;
            prev_valid_q <= 1'b1;
        end
    end
`endif

    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = colour_q;
    assign bus.plot       = plot_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_block_drawer.sv
// tb_block_drawer: directed checks of block_drawer. Expected pixel streams are
// built from the request constants. Erase expectations follow BLOCK_DRAWER_ERASE_EN.
module tb_block_drawer;

    logic clk = 1'b0;
    logic reset;

    block_drawer_if bus ();

    block_drawer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clk = ~clk;

`ifdef BLOCK_DRAWER_ERASE_EN
    localparam bit ERASE_EN = 1'b1;
`else
    localparam bit ERASE_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Sample word: {plot, busy, done, vga_x[7:0], vga_y[6:0], vga_colour[2:0]}
    logic [20:0] cap [0:63];

    function automatic logic [20:0] pix(input logic p, input logic b, input logic d,
                                        input int x, input int y, input logic [2:0] c);
        return {p, b, d, 8'(x), 7'(y), c};
    endfunction

    // Record n consecutive output samples, each taken on the falling edge.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap[i] = {bus.plot, bus.busy, bus.done, bus.vga_x, bus.vga_y, bus.vga_colour};
        end
    endtask

    // Present a one-cycle start. The task returns on the falling edge just after the start edge.
    task automatic issue_start(input int x, input int y, input int w, input logic [2:0] c);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.x_in      = 8'(x);
        bus.y_in      = 7'(y);
        bus.width_in  = 8'(w);
        bus.colour_in = c;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [20:0] got;
        do_reset();
        got = {bus.plot, bus.busy, bus.done, bus.vga_x, bus.vga_y, bus.vga_colour};
        checks++;
        if (got !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp %h", got, 21'd0);
        end
        capture(4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap[i] !== 21'd0) begin
                errors++;
                $display("FAIL reset_idle[%0d] got %h exp %h", i, cap[i], 21'd0);
            end
        end
    endtask

    task automatic test_first_draw();
        logic [20:0] exp;
        do_reset();
        issue_start(10, 20, 4, 3'b100);
        checks++;
        if ({bus.plot, bus.busy, bus.done} !== 3'b010) begin
            errors++;
            $display("FAIL first_start_edge got %b exp 010", {bus.plot, bus.busy, bus.done});
        end
        capture(34);
        for (int i = 0; i < 32; i++) begin
            exp = pix(1'b1, 1'b1, 1'b0, 10 + i % 4, 20 + i / 4, 3'b100);
            checks++;
            if (cap[i] !== exp) begin
                errors++;
                $display("FAIL first_draw[%0d] got %h exp %h", i, cap[i], exp);
            end
        end
        checks++;
        if (cap[32][20:18] !== 3'b001) begin
            errors++;
            $display("FAIL first_done got %b exp 001", cap[32][20:18]);
        end
        checks++;
        if (cap[33][20:18] !== 3'b000) begin
            errors++;
            $display("FAIL first_after_done got %b exp 000", cap[33][20:18]);
        end
    endtask

    // Runs straight after test_first_draw, so the previous block is (10,20) width 4.
    task automatic test_erase_then_draw();
        logic [20:0] exp;
        int e;
        int t;
        int j;
        e = ERASE_EN ? 32 : 0;
        t = e + 24;
        issue_start(12, 20, 3, 3'b010);
        capture(58);
        for (int i = 0; i < t; i++) begin
            if (i < e) begin
                exp = pix(1'b1, 1'b1, 1'b0, 10 + i % 4, 20 + i / 4, 3'b000);
            end else begin
                j = i - e;
                exp = pix(1'b1, 1'b1, 1'b0, 12 + j % 3, 20 + j / 3, 3'b010);
            end
            checks++;
            if (cap[i] !== exp) begin
                errors++;
                $display("FAIL erase_draw[%0d] got %h exp %h", i, cap[i], exp);
            end
        end
        checks++;
        if (cap[t][20:18] !== 3'b001) begin
            errors++;
            $display("FAIL erase_draw_done got %b exp 001", cap[t][20:18]);
        end
        checks++;
        if (cap[t + 1][20:18] !== 3'b000) begin
            errors++;
            $display("FAIL erase_draw_after_done got %b exp 000", cap[t + 1][20:18]);
        end
    endtask

    task automatic test_clip();
        logic [20:0] exp;
        int plots;
        int px;
        plots = 0;
        do_reset();
        issue_start(158, 5, 4, 3'b011);
        capture(34);
        for (int i = 0; i < 32; i++) begin
            px = i % 4;
            plots += int'(cap[i][20]);
            checks++;
            if (px < 2) begin
                exp = pix(1'b1, 1'b1, 1'b0, 158 + px, 5 + i / 4, 3'b011);
                if (cap[i] !== exp) begin
                    errors++;
                    $display("FAIL clip_visible[%0d] got %h exp %h", i, cap[i], exp);
                end
            end else if (cap[i][20:18] !== 3'b010) begin
                errors++;
                $display("FAIL clip_hidden[%0d] got %b exp 010", i, cap[i][20:18]);
            end
        end
        checks++;
        if (plots != 16) begin
            errors++;
            $display("FAIL clip_plot_count got %0d exp 16", plots);
        end
        checks++;
        if (cap[32][20:18] !== 3'b001) begin
            errors++;
            $display("FAIL clip_done got %b exp 001", cap[32][20:18]);
        end
    endtask

    task automatic test_zero_width();
        logic [20:0] exp;
        do_reset();
        issue_start(50, 10, 0, 3'b111);
        checks++;
        if ({bus.plot, bus.busy, bus.done} !== 3'b010) begin
            errors++;
            $display("FAIL zero_start_edge got %b exp 010", {bus.plot, bus.busy, bus.done});
        end
        capture(3);
        checks++;
        if (cap[0][20:18] !== 3'b001) begin
            errors++;
            $display("FAIL zero_done got %b exp 001", cap[0][20:18]);
        end
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (cap[i][20:18] !== 3'b000) begin
                errors++;
                $display("FAIL zero_after[%0d] got %b exp 000", i, cap[i][20:18]);
            end
        end
        // The remembered block has width 0, so this request must start drawing at once.
        issue_start(30, 40, 2, 3'b001);
        capture(18);
        for (int i = 0; i < 16; i++) begin
            exp = pix(1'b1, 1'b1, 1'b0, 30 + i % 2, 40 + i / 2, 3'b001);
            checks++;
            if (cap[i] !== exp) begin
                errors++;
                $display("FAIL zero_next_draw[%0d] got %h exp %h", i, cap[i], exp);
            end
        end
        checks++;
        if (cap[16][20:18] !== 3'b001) begin
            errors++;
            $display("FAIL zero_next_done got %b exp 001", cap[16][20:18]);
        end
    endtask

    task automatic test_start_while_busy();
        logic [20:0] exp;
        do_reset();
        issue_start(20, 30, 4, 3'b101);
        fork
            capture(40);
            begin
                repeat (4) @(negedge clk);
                bus.start     = 1'b1;
                bus.x_in      = 8'd99;
                bus.y_in      = 7'd1;
                bus.width_in  = 8'd1;
                bus.colour_in = 3'b111;
                @(negedge clk);
                bus.start = 1'b0;
            end
        join
        for (int i = 0; i < 32; i++) begin
            exp = pix(1'b1, 1'b1, 1'b0, 20 + i % 4, 30 + i / 4, 3'b101);
            checks++;
            if (cap[i] !== exp) begin
                errors++;
                $display("FAIL busy_start_stream[%0d] got %h exp %h", i, cap[i], exp);
            end
        end
        checks++;
        if (cap[32][20:18] !== 3'b001) begin
            errors++;
            $display("FAIL busy_start_done got %b exp 001", cap[32][20:18]);
        end
        for (int i = 33; i < 40; i++) begin
            checks++;
            if (cap[i][20:18] !== 3'b000) begin
                errors++;
                $display("FAIL busy_start_queued[%0d] got %b exp 000", i, cap[i][20:18]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [20:0] exp;
        do_reset();
        // Complete one block first so that an erase would be pending if reset failed to clear it.
        issue_start(40, 50, 2, 3'b110);
        capture(17);
        checks++;
        if (cap[16][20:18] !== 3'b001) begin
            errors++;
            $display("FAIL mid_setup_done got %b exp 001", cap[16][20:18]);
        end
        issue_start(60, 50, 4, 3'b010);
        capture(10);
        checks++;
        if (cap[9][20:18] !== 3'b110) begin
            errors++;
            $display("FAIL mid_running got %b exp 110", cap[9][20:18]);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.plot, bus.busy, bus.done} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset_edge got %b exp 000", {bus.plot, bus.busy, bus.done});
        end
        reset = 1'b0;
        capture(40);
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (cap[i][20:18] !== 3'b000) begin
                errors++;
                $display("FAIL mid_quiet[%0d] got %b exp 000", i, cap[i][20:18]);
            end
        end
        issue_start(70, 60, 2, 3'b001);
        capture(18);
        for (int i = 0; i < 16; i++) begin
            exp = pix(1'b1, 1'b1, 1'b0, 70 + i % 2, 60 + i / 2, 3'b001);
            checks++;
            if (cap[i] !== exp) begin
                errors++;
                $display("FAIL mid_after_draw[%0d] got %h exp %h", i, cap[i], exp);
            end
        end
        checks++;
        if (cap[16][20:18] !== 3'b001) begin
            errors++;
            $display("FAIL mid_after_done got %b exp 001", cap[16][20:18]);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.x_in      = 8'd0;
        bus.y_in      = 7'd0;
        bus.width_in  = 8'd0;
        bus.colour_in = 3'd0;

        test_reset();
        test_first_draw();
        test_erase_then_draw();
        test_clip();
        test_zero_width();
        test_start_while_busy();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/block_drawer.md
Name: block_drawer

Overview:
- Consumes the moving block's x coordinate, plus y, width and colour, and converts it into a stream of single-pixel writes for the VGA adapter.
- On each start request it optionally erases the previously drawn rectangle in the background colour, then rasterises the new rectangle one pixel per clock.
- Sits between the game datapath (position registers, control FSM) and the VGA adapter's x/y/colour/plot inputs.

Parameters:
- BLOCK_H, 8, block height in pixels (fixed for all blocks)
- SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are clipped
- BG_COLOUR, 3'b000, colour used for erase passes

Ports:
- clk  input  1  system clock (50 MHz)
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to draw a block; ignored while busy
- x_in  input  8  left x of new block, sampled on accepted start
- y_in  input  7  top y of new block, sampled on accepted start
- width_in  input  8  block width in pixels, sampled on accepted start; 0 is legal
- colour_in  input  3  block colour, sampled on accepted start
- vga_x  output  8  pixel x to VGA adapter
- vga_y  output  7  pixel y to VGA adapter
- vga_colour  output  3  pixel colour
- plot  output  1  write strobe; pixel fields are valid when high
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when the operation completes

Behaviour:
- Reset values: every output is 0; state is IDLE; the prev_valid flag is cleared; the counters are cleared.
- States: IDLE, ERASE, DRAW, FINISH.
- IDLE: start=1 at edge N latches x_in, y_in, width_in and colour_in.
  - Goes to ERASE if prev_valid=1 and prev_w != 0; otherwise goes to DRAW.
  - busy=1 from edge N.
- Pixel emission:
  - px and py start at 0. One pixel is emitted per cycle.
  - px increments fastest over 0..w-1; on wrap, py increments over 0..BLOCK_H-1.
  - Outputs are registered: vga_x = base_x + px (8-bit), vga_y = base_y + py (7-bit).
  - The first pixel is valid after edge N+1.
- ERASE:
  - base = prev_x/prev_y, w = prev_w, colour = BG_COLOUR.
  - After the last pixel (px=prev_w-1, py=BLOCK_H-1), transitions directly to DRAW with no bubble cycle.
- DRAW:
  - base = latched new x/y, w = new width, colour = latched colour.
  - width 0: DRAW emits nothing and goes straight to FINISH.
- FINISH:
  - plot=0 and done=1 for exactly one cycle. busy drops on the same edge done rises.
  - prev_x/prev_y/prev_w are updated to the new block, prev_valid is set to 1, then the state returns to IDLE.
- Clipping: if base_x + px >= SCREEN_W, or the 8-bit sum overflows, plot=0 for that cycle. The counter still advances, so cycle count is unaffected.
- Latency:
  - Erase pass takes prev_w*BLOCK_H cycles. Draw pass takes w*BLOCK_H cycles.
  - The done edge is 1 + erase cycles + draw cycles after the start edge.
- Start while busy: ignored and not queued. Latched values do not change mid-operation.
- Reset mid-operation: on the next edge, return to IDLE with plot=0, busy=0, done=0 and prev_valid=0. A partially drawn rectangle is left on screen.
- plot is never high in IDLE or FINISH.

Optional Feature:
- Macro: BLOCK_DRAWER_ERASE_EN.
- Defined: the ERASE state and the prev_* registers exist, behaving as above.
- Undefined:
  - The ERASE state and prev_* registers are removed.
  - An accepted start always goes straight to DRAW.
  - The done edge is 1 + w*BLOCK_H cycles after start.
  - The caller is responsible for clearing old pixels.

Test Plan:
- Reset, then start with x=10, y=20, w=4, colour=3'b100 (no previous block):
  - plot is high for 32 consecutive cycles, with first pixel (10,20) and last pixel (13,27), all colour 100.
  - done pulses 33 cycles after start; busy is high throughout.
- Follow with start x=12, y=20, w=3, colour=3'b010:
  - 32 erase pixels of colour 000 at (10..13, 20..27), then 24 draw pixels at (12..14, 20..27).
  - No gap between passes; done at +57.
- Start with x=158, w=4 after reset: only x=158 and 159 strobe plot (16 plots over 32 cycles); done at +33.
- Start with w=0 after reset: plot never asserts; done at +1; prev_valid=1 with prev_w=0, so the next start skips ERASE.
- Assert start again 5 cycles into a draw: no effect on the pixel stream or done timing.
- Assert reset 10 cycles into a draw:
  - plot and busy are 0 after the next edge; done never pulses.
  - A subsequent start performs no erase pass.
